// File: rtl/palette_lut.sv
// Run-time loadable colour palette with a 2-cycle lookup pipeline and a frame-stepped fade engine.
// Optional feature: define PALETTE_TRANSPARENT_EN to flag lookups of KEY_IDX as transparent.
module palette_lut #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned LVL_W   = 4,
    parameter int unsigned KEY_IDX = 0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 pix_valid,
    input  logic [INDEX_W-1:0]   index,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_addr,
    input  logic [3*COLOR_W-1:0] wr_data,
    input  logic                 frame_tick,
    input  logic                 fade_out_req,
    input  logic                 fade_in_req,
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 transparent,
    output logic                 fade_busy,
    output logic [LVL_W-1:0]     level
);

    localparam int unsigned DEPTH   = 2 ** INDEX_W;
    localparam int unsigned GREY_SHL = (COLOR_W >= INDEX_W) ? COLOR_W - INDEX_W : 0;
    localparam int unsigned GREY_SHR = (INDEX_W > COLOR_W) ? INDEX_W - COLOR_W : 0;
    localparam logic [LVL_W-1:0] LVL_MAX = '1;

    typedef enum logic [1:0] {StFull, StFadeOut, StBlack, StFadeIn} fade_state_e;

    function automatic logic [COLOR_W-1:0] grey(input int unsigned i);
        logic [31:0] v;
        v = 32'(i);
        v = (v << GREY_SHL) >> GREY_SHR;
        return v[COLOR_W-1:0];
    endfunction

    // (chan * s) >> LVL_W with s <= 2**LVL_W, so the result always fits COLOR_W bits.
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] chan,
                                                 input logic [LVL_W:0]     s);
        logic [COLOR_W+LVL_W:0] p;
        p = {{(LVL_W+1){1'b0}}, chan} * {{COLOR_W{1'b0}}, s};
        p = p >> LVL_W;
        return p[COLOR_W-1:0];
    endfunction

    logic [3*COLOR_W-1:0] r_pal [DEPTH];
    logic                 r_s1_valid;
    logic [3*COLOR_W-1:0] r_s1_rgb;
    logic                 r_out_valid;
    logic [COLOR_W-1:0]   r_red, r_green, r_blue;
    fade_state_e          r_state, w_state_d;
    logic [LVL_W-1:0]     r_level, w_level_d;
    logic [3*COLOR_W-1:0] w_rd;
    logic [LVL_W:0]       w_scale;

    // Palette storage: grey ramp on reset, single write port.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pal[i] <= {3{grey(unsigned'(i))}};
            end
        end else if (wr_en) begin
            r_pal[wr_addr] <= wr_data;
        end
    end

    // Write-first bypass so a same-cycle write is visible to the lookup.
    assign w_rd = (wr_en && (wr_addr == index)) ? wr_data : r_pal[index];

    assign w_scale = (r_level == '0) ? '0 : ({1'b0, r_level} + (LVL_W+1)'(1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_rgb    <= '0;
            r_out_valid <= 1'b0;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
        end else begin
            r_s1_valid  <= pix_valid;
            r_out_valid <= r_s1_valid;
            if (pix_valid) begin
                r_s1_rgb <= w_rd;
            end
            if (r_s1_valid) begin
                r_red   <= scale(r_s1_rgb[3*COLOR_W-1:2*COLOR_W], w_scale);
                r_green <= scale(r_s1_rgb[2*COLOR_W-1:COLOR_W], w_scale);
                r_blue  <= scale(r_s1_rgb[COLOR_W-1:0], w_scale);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;

`ifdef PALETTE_TRANSPARENT_EN
    logic r_s1_key;
    logic r_transparent;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_key      <= 1'b0;
            r_transparent <= 1'b0;
        end else begin
            if (pix_valid) begin
                r_s1_key <= (index == INDEX_W'(KEY_IDX));
            end
            if (r_s1_valid) begin
                r_transparent <= r_s1_key;
            end
        end
    end

    assign transparent = r_transparent;
`else
    logic w_unused_key;
    assign w_unused_key = (index == INDEX_W'(KEY_IDX));
    assign transparent  = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StFull;
            r_level <= LVL_MAX;
        end else begin
            r_state <= w_state_d;
            r_level <= w_level_d;
        end
    end

    // A direction change consumes the cycle; stepping resumes on the following tick.
    always_comb begin
        w_state_d = r_state;
        w_level_d = r_level;
        case (r_state)
            StFull: begin
                if (fade_out_req) begin
                    w_state_d = StFadeOut;
                end
            end
            StBlack: begin
                if (fade_in_req && !fade_out_req) begin
                    w_state_d = StFadeIn;
                end
            end
            StFadeOut: begin
                if (fade_in_req && !fade_out_req) begin
                    w_state_d = StFadeIn;
                end else if (frame_tick) begin
                    if (r_level <= LVL_W'(1)) begin
                        w_level_d = '0;
                        w_state_d = StBlack;
                    end else begin
                        w_level_d = r_level - LVL_W'(1);
                    end
                end
            end
            StFadeIn: begin
                if (fade_out_req) begin
                    w_state_d = StFadeOut;
                end else if (frame_tick) begin
                    if (r_level >= LVL_MAX - LVL_W'(1)) begin
                        w_level_d = LVL_MAX;
                        w_state_d = StFull;
                    end else begin
                        w_level_d = r_level + LVL_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = StFull;
                w_level_d = LVL_MAX;
            end
        endcase
    end

    assign fade_busy = (r_state == StFadeOut) || (r_state == StFadeIn);
    assign level     = r_level;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: directed scenarios plus randomized lookup/write and
// fade traffic compared against a behavioural palette and brightness model.
module tb_palette_lut;

    logic        Clk;
    logic        Reset_n;
    logic        pix_valid;
    logic [3:0]  index;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_tick;
    logic        fade_out_req;
    logic        fade_in_req;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        fade_busy;
    logic [3:0]  level;

`ifdef PALETTE_TRANSPARENT_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] mpal [16];

    typedef struct packed {
        logic        v;
        logic [11:0] c;
    } exp_t;

    palette_lut dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pix_valid    (pix_valid),
        .index        (index),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_tick   (frame_tick),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .out_valid    (out_valid),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .transparent  (transparent),
        .fade_busy    (fade_busy),
        .level        (level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Brightness applied to one channel: level 15 is identity, level 0 is black.
    function automatic int exp_scale(input int chan, input int lvl);
        int s;
        s = (lvl == 0) ? 0 : lvl + 1;
        return (chan * s) / 16;
    endfunction

    task automatic reset_dut();
        pix_valid = 0; index = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        frame_tick = 0; fade_out_req = 0; fade_in_req = 0;
        Reset_n = 0;
        step();
        step();
        Reset_n = 1;
        for (int i = 0; i < 16; i++) begin
            mpal[i] = {3{4'(i)}};
        end
    endtask

    task automatic lookup(input logic [3:0] idx);
        pix_valid = 1;
        index = idx;
        step();
        pix_valid = 0;
        step();
    endtask

    task automatic tick();
        frame_tick = 1;
        step();
        frame_tick = 0;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [11:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        step();
        wr_en = 0;
        mpal[a] = d;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_checks++;
        if ({red, green, blue} !== 12'h000) begin
            n_fail++; $display("FAIL reset_rgb got=%h want=000", {red, green, blue});
        end
        n_checks++;
        if (level !== 4'd15 || fade_busy !== 1'b0 || transparent !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fade got level=%0d busy=%b tr=%b want 15,0,0",
                     level, fade_busy, transparent);
        end
        pix_valid = 1; index = 4'd5;
        step();
        pix_valid = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lookup_latency_n1 got=%b want=0", out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== 12'h555) begin
            n_fail++;
            $display("FAIL grey_lookup5 got v=%b rgb=%h want v=1 rgb=555",
                     out_valid, {red, green, blue});
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 12'h555) begin
            n_fail++;
            $display("FAIL hold_after_valid got v=%b rgb=%h want v=0 rgb=555",
                     out_valid, {red, green, blue});
        end
    endtask

    task automatic test_write_first();
        wr_en = 1; wr_addr = 4'd3; wr_data = 12'hEA1;
        pix_valid = 1; index = 4'd3;
        step();
        wr_en = 0; pix_valid = 0;
        mpal[3] = 12'hEA1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== 12'hEA1) begin
            n_fail++;
            $display("FAIL write_first got v=%b rgb=%h want v=1 rgb=EA1",
                     out_valid, {red, green, blue});
        end
        lookup(4'd3);
        n_checks++;
        if ({red, green, blue} !== 12'hEA1) begin
            n_fail++; $display("FAIL write_stored got=%h want=EA1", {red, green, blue});
        end
    endtask

    task automatic test_random_lookup();
        exp_t        q[$];
        exp_t        e;
        logic [11:0] held;
        reset_dut();
        held = 12'h000;
        for (int n = 0; n < 300; n++) begin
            pix_valid = 1'($urandom_range(0, 1));
            index     = 4'($urandom);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = (n % 7 == 0) ? index : 4'($urandom);
            wr_data   = 12'($urandom);
            e.v = pix_valid;
            e.c = (wr_en && wr_addr == index) ? wr_data : mpal[index];
            if (wr_en) mpal[wr_addr] = wr_data;
            q.push_back(e);
            step();
            if (q.size() >= 2) begin
                e = q.pop_front();
                if (e.v) held = e.c;
                n_checks++;
                if (out_valid !== e.v || {red, green, blue} !== held) begin
                    n_fail++;
                    $display("FAIL random_lookup[%0d] got v=%b rgb=%h want v=%b rgb=%h",
                             n, out_valid, {red, green, blue}, e.v, held);
                end
            end
        end
        pix_valid = 0; wr_en = 0;
        step();
        e = q.pop_front();
        if (e.v) held = e.c;
        n_checks++;
        if (out_valid !== e.v || {red, green, blue} !== held) begin
            n_fail++;
            $display("FAIL random_lookup_drain got v=%b rgb=%h want v=%b rgb=%h",
                     out_valid, {red, green, blue}, e.v, held);
        end
    endtask

    task automatic test_fade_out();
        int ev;
        reset_dut();
        write_entry(4'd13, 12'hEEE);
        fade_out_req = 1;
        step();
        fade_out_req = 0;
        n_checks++;
        if (fade_busy !== 1'b1 || level !== 4'd15) begin
            n_fail++;
            $display("FAIL fade_out_start got busy=%b level=%0d want 1,15", fade_busy, level);
        end
        for (int k = 14; k >= 0; k--) begin
            tick();
            n_checks++;
            if (level !== 4'(k) || fade_busy !== (k != 0)) begin
                n_fail++;
                $display("FAIL fade_out_step got level=%0d busy=%b want %0d,%b",
                         level, fade_busy, k, (k != 0));
            end
            if (k == 7 || k == 3) begin
                lookup(4'd13);
                ev = exp_scale(14, k);
                n_checks++;
                if (out_valid !== 1'b1 || {red, green, blue} !== {3{4'(ev)}}) begin
                    n_fail++;
                    $display("FAIL fade_scaled_lvl%0d got rgb=%h want %h",
                             k, {red, green, blue}, {3{4'(ev)}});
                end
            end
        end
        lookup(4'd13);
        n_checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin
            n_fail++; $display("FAIL fade_black_rgb got=%h want=000", {red, green, blue});
        end
    endtask

    task automatic test_reverse();
        fade_in_req = 1;
        step();
        fade_in_req = 0;
        repeat (15) tick();
        n_checks++;
        if (level !== 4'd15 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fade_in_full got level=%0d busy=%b want 15,0", level, fade_busy);
        end
        fade_out_req = 1;
        step();
        fade_out_req = 0;
        repeat (6) tick();
        n_checks++;
        if (level !== 4'd9) begin
            n_fail++; $display("FAIL fade_to_9 got=%0d want=9", level);
        end
        fade_in_req = 1; frame_tick = 1;
        step();
        fade_in_req = 0; frame_tick = 0;
        n_checks++;
        if (level !== 4'd9 || fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reverse_no_step got level=%0d busy=%b want 9,1", level, fade_busy);
        end
        tick();
        n_checks++;
        if (level !== 4'd10) begin
            n_fail++; $display("FAIL reverse_step got=%0d want=10", level);
        end
        fade_out_req = 1; fade_in_req = 1;
        step();
        fade_out_req = 0; fade_in_req = 0;
        tick();
        n_checks++;
        if (level !== 4'd9) begin
            n_fail++; $display("FAIL both_req_during_in got=%0d want=9", level);
        end
        fade_in_req = 1;
        step();
        fade_in_req = 0;
        repeat (6) tick();
        fade_out_req = 1; fade_in_req = 1;
        step();
        fade_out_req = 0; fade_in_req = 0;
        n_checks++;
        if (fade_busy !== 1'b1 || level !== 4'd15) begin
            n_fail++;
            $display("FAIL both_req_from_full got busy=%b level=%0d want 1,15", fade_busy, level);
        end
        tick();
        n_checks++;
        if (level !== 4'd14) begin
            n_fail++; $display("FAIL both_req_dir got=%0d want=14", level);
        end
    endtask

    task automatic test_random_fade();
        int mlvl;
        int mdir;
        bit changed;
        reset_dut();
        mlvl = 15;
        mdir = 0;
        for (int n = 0; n < 400; n++) begin
            frame_tick   = ($urandom_range(0, 2) == 0);
            fade_out_req = ($urandom_range(0, 11) == 0);
            fade_in_req  = ($urandom_range(0, 11) == 0);
            changed = 0;
            if (fade_out_req) begin
                if (mdir == 1 || (mdir == 0 && mlvl == 15)) begin
                    mdir = -1; changed = 1;
                end
            end else if (fade_in_req) begin
                if (mdir == -1 || (mdir == 0 && mlvl == 0)) begin
                    mdir = 1; changed = 1;
                end
            end
            if (!changed && frame_tick && mdir != 0) begin
                mlvl = mlvl + mdir;
                if (mlvl < 0) mlvl = 0;
                if (mlvl > 15) mlvl = 15;
                if (mlvl == 0 || mlvl == 15) mdir = 0;
            end
            step();
            n_checks++;
            if (level !== 4'(mlvl) || fade_busy !== (mdir != 0)) begin
                n_fail++;
                $display("FAIL random_fade[%0d] got level=%0d busy=%b want %0d,%b",
                         n, level, fade_busy, mlvl, (mdir != 0));
            end
        end
        frame_tick = 0; fade_out_req = 0; fade_in_req = 0;
    endtask

    task automatic test_reset_mid();
        reset_dut();
        write_entry(4'd13, 12'hEEE);
        fade_out_req = 1;
        step();
        fade_out_req = 0;
        repeat (3) tick();
        pix_valid = 1; index = 4'd13;
        step();
        pix_valid = 0;
        #2 Reset_n = 0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 4'd15 || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b level=%0d busy=%b want 0,15,0",
                     out_valid, level, fade_busy);
        end
        step();
        Reset_n = 1;
        for (int i = 0; i < 16; i++) mpal[i] = {3{4'(i)}};
        step();
        n_checks++;
        if (out_valid !== 1'b0 || {red, green, blue} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_flush got v=%b rgb=%h want 0,000", out_valid, {red, green, blue});
        end
        lookup(4'd13);
        n_checks++;
        if (out_valid !== 1'b1 || {red, green, blue} !== mpal[13]) begin
            n_fail++;
            $display("FAIL reset_grey13 got rgb=%h want %h", {red, green, blue}, mpal[13]);
        end
    endtask

    task automatic test_transparent();
        lookup(4'd0);
        n_checks++;
        if (transparent !== TRANSP_EN || {red, green, blue} !== mpal[0]) begin
            n_fail++;
            $display("FAIL transparent_key got tr=%b rgb=%h want %b,%h",
                     transparent, {red, green, blue}, TRANSP_EN, mpal[0]);
        end
        lookup(4'd1);
        n_checks++;
        if (transparent !== 1'b0 || {red, green, blue} !== mpal[1]) begin
            n_fail++;
            $display("FAIL transparent_nonkey got tr=%b rgb=%h want 0,%h",
                     transparent, {red, green, blue}, mpal[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_first();
        test_random_lookup();
        test_fade_out();
        test_reverse();
        test_random_fade();
        test_reset_mid();
        test_transparent();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
